mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the EXE stage and the WB stage.
- Accepts one instruction per handshake from EXE.
- Collects the synchronous data-SRAM read data for loads that EXE issued in the previous cycle, then sign- or zero-extends byte/halfword loads.
- Presents the register write-back value to WB and on a bypass port to ID.
- Holds load data stable across WB back-pressure, even though EXE keeps driving the SRAM while this stage is stalled.

## Interface
Parameters: none.
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared immediately while low
- ready_go_exe  in  1  EXE holds a valid instruction ready to advance
- allow_in  out  1  this stage accepts an instruction this cycle
- inst_from_exe  in  32  instruction word
- pc_from_exe  in  32  instruction PC
- alu_result_from_exe  in  32  ALU result / memory address
- reg_en_from_exe  in  1  instruction writes the register file
- mem_ld_from_exe  in  1  instruction is a load
- dest_from_exe  in  5  destination register
- data_sram_rdata  in  32  data SRAM read data, valid the cycle after EXE drove the request
- ready_go  out  1  instruction ready to leave to WB
- WB_allow_in  in  1  WB accepts this cycle
- inst_mem  out  32  registered instruction
- pc_mem  out  32  registered PC
- final_result  out  32  write-back value
- reg_en  out  1  registered write enable, not gated by valid
- dest  out  5  registered destination
- valid  out  1  stage holds a live instruction
- forward_data_mem  out  32  bypass value, equals final_result
- forward_en_mem  out  1  bypass qualifier, equals valid & reg_en

## Operation
Handshake:
- accept = ready_go_exe & allow_in.
- allow_in = ~valid | (ready_go & WB_allow_in).
- ready_go = valid; the stage never stalls on its own.

valid update, in priority order:
- reset low: 0.
- accept: 1.
- else ready_go & WB_allow_in: 0.
- else hold.

Payload registers (inst, pc, alu_result, reg_en, mem_ld, dest):
- Loaded on accept only.
- Reset to 0.

Load data capture:
- first_cycle flag: set on accept, cleared on any other cycle.
- When first_cycle=1, rdata_hold <= data_sram_rdata.
- ld_word = first_cycle ? data_sram_rdata : rdata_hold.
- Data is taken only in the first cycle, because during a WB stall EXE may issue a different access and the SRAM output then changes.

Load width is decoded from inst_mem[31:22]:
- 0x0a0 ld.b, sign-extended.
- 0x0a1 ld.h, sign-extended.
- 0x0a2 ld.w.
- 0x0a8 ld.bu, zero-extended.
- 0x0a9 ld.hu, zero-extended.
- Any other opcode with mem_ld=1 is treated as ld.w.

Lane select (addr = alu_result reg):
- Byte: lane addr[1:0], i.e. bits [8*addr[1:0]+7 : 8*addr[1:0]].
- Half: addr[1]=0 gives [15:0], addr[1]=1 gives [31:16].
- addr[0] is ignored for halfwords. Misalignment is not checked; exceptions belong to a later experiment.

final_result:
- mem_ld=1: the extended load value.
- mem_ld=0: the registered alu_result.

## Timing
Reset values, all 0: valid, ready_go, inst_mem, pc_mem, final_result (alu_result reg 0), reg_en, dest, first_cycle, rdata_hold, forward_en_mem.
- Latency: an instruction accepted at edge N is visible to WB at cycle N; with WB_allow_in=1 it leaves at edge N+1, giving throughput 1 per cycle.
- Accept and departure at the same edge: the new payload overwrites, valid stays 1 and first_cycle=1.
- WB stall for k cycles: all outputs, including final_result for loads, stay constant for all k+1 cycles, independent of data_sram_rdata after the first cycle.
- Reset low mid-stall or during the first cycle: valid drops asynchronously, the instruction is discarded, and rdata_hold clears.
- forward_en_mem is combinational from registers only; there is no path from data_sram_rdata to forward_en_mem. forward_data_mem does depend combinationally on data_sram_rdata in the first cycle.

## Test plan
- Reset: drive reset=0 mid-operation, then release -> all outputs 0, allow_in=1.
- Back-to-back ALU ops, WB_allow_in=1: accept alu_result 0x11, 0x22, 0x33 on successive edges -> final_result shows 0x11, 0x22, 0x33 on consecutive cycles; valid stays 1; forward_en_mem=1.
- ld.w with WB stall:
  - Stimulus: rdata 0xDEADBEEF in the first cycle; WB_allow_in=0 for 3 cycles; data_sram_rdata changes to 0x12345678 from the next cycle.
  - Required: final_result stays 0xDEADBEEF throughout; allow_in=0 during the stall.
  - Release: the instruction leaves on the release edge.
- Byte/half extension, rdata 0x80FF7F01:
  - ld.b, addr 0 -> 0x00000001.
  - ld.b, addr 2 -> 0xFFFFFFFF.
  - ld.bu, addr 3 -> 0x00000080.
  - ld.h, addr 2 -> 0xFFFF80FF.
  - ld.hu, addr 0 -> 0x00007F01.
- Simultaneous accept and departure: valid=1, WB_allow_in=1, ready_go_exe=1 -> new pc replaces old in one edge with no bubble; a new load captures its own rdata.
- reg_en=0 store passing through -> forward_en_mem=0; final_result = address.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EXE and WB.
// Captures SRAM load data on the first cycle so a WB stall cannot corrupt it.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready_go_exe,
  output logic        allow_in,
  input  logic [31:0] inst_from_exe,
  input  logic [31:0] pc_from_exe,
  input  logic [31:0] alu_result_from_exe,
  input  logic        reg_en_from_exe,
  input  logic        mem_ld_from_exe,
  input  logic [4:0]  dest_from_exe,
  input  logic [31:0] data_sram_rdata,
  output logic        ready_go,
  input  logic        WB_allow_in,
  output logic [31:0] inst_mem,
  output logic [31:0] pc_mem,
  output logic [31:0] final_result,
  output logic        reg_en,
  output logic [4:0]  dest,
  output logic        valid,
  output logic [31:0] forward_data_mem,
  output logic        forward_en_mem
);

  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic        reg_en_q, reg_en_d;
  logic        mem_ld_q, mem_ld_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] hold_q, hold_d;

  logic        accept;
  logic [31:0] ld_word;
  logic [31:0] ld_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [9:0]  op;

  assign ready_go = valid_q;
  assign allow_in = ~valid_q | (ready_go & WB_allow_in);
  assign accept   = ready_go_exe & allow_in;

  always_comb begin
    valid_d = valid_q;
    if (accept)
      valid_d = 1'b1;
    else if (ready_go & WB_allow_in)
      valid_d = 1'b0;
    first_d  = accept;
    hold_d   = first_q ? data_sram_rdata : hold_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    reg_en_d = reg_en_q;
    mem_ld_d = mem_ld_q;
    dest_d   = dest_q;
    if (accept) begin
      inst_d   = inst_from_exe;
      pc_d     = pc_from_exe;
      alu_d    = alu_result_from_exe;
      reg_en_d = reg_en_from_exe;
      mem_ld_d = mem_ld_from_exe;
      dest_d   = dest_from_exe;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      alu_q    <= '0;
      reg_en_q <= 1'b0;
      mem_ld_q <= 1'b0;
      dest_q   <= '0;
      hold_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      first_q  <= first_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      alu_q    <= alu_d;
      reg_en_q <= reg_en_d;
      mem_ld_q <= mem_ld_d;
      dest_q   <= dest_d;
      hold_q   <= hold_d;
    end
  end

  // SRAM output is only trustworthy in the first cycle after accept
  always_comb begin
    ld_word = first_q ? data_sram_rdata : hold_q;
    op      = inst_q[31:22];
    case (alu_q[1:0])
      2'd0:    byte_v = ld_word[7:0];
      2'd1:    byte_v = ld_word[15:8];
      2'd2:    byte_v = ld_word[23:16];
      default: byte_v = ld_word[31:24];
    endcase
    half_v = alu_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (op)
      10'h0a0: ld_val = {{24{byte_v[7]}}, byte_v};
      10'h0a1: ld_val = {{16{half_v[15]}}, half_v};
      10'h0a8: ld_val = {24'd0, byte_v};
      10'h0a9: ld_val = {16'd0, half_v};
      default: ld_val = ld_word;
    endcase
  end

  assign final_result     = mem_ld_q ? ld_val : alu_q;
  assign inst_mem         = inst_q;
  assign pc_mem           = pc_q;
  assign reg_en           = reg_en_q;
  assign dest             = dest_q;
  assign valid            = valid_q;
  assign forward_data_mem = final_result;
  assign forward_en_mem   = valid_q & reg_en_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random stimulus for mem_stage
// against a transaction-level reference model.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ready_go_exe;
  logic        allow_in;
  logic [31:0] inst_from_exe;
  logic [31:0] pc_from_exe;
  logic [31:0] alu_result_from_exe;
  logic        reg_en_from_exe;
  logic        mem_ld_from_exe;
  logic [4:0]  dest_from_exe;
  logic [31:0] data_sram_rdata;
  logic        ready_go;
  logic        WB_allow_in;
  logic [31:0] inst_mem;
  logic [31:0] pc_mem;
  logic [31:0] final_result;
  logic        reg_en;
  logic [4:0]  dest;
  logic        valid;
  logic [31:0] forward_data_mem;
  logic        forward_en_mem;

  int checks = 0;
  int errors = 0;

  // reference model: the one instruction held by the stage
  logic        m_valid, m_first, m_re, m_ld;
  logic [31:0] m_inst, m_pc, m_alu, m_word;
  logic [4:0]  m_dst;

  mem_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .ready_go_exe        (ready_go_exe),
    .allow_in            (allow_in),
    .inst_from_exe       (inst_from_exe),
    .pc_from_exe         (pc_from_exe),
    .alu_result_from_exe (alu_result_from_exe),
    .reg_en_from_exe     (reg_en_from_exe),
    .mem_ld_from_exe     (mem_ld_from_exe),
    .dest_from_exe       (dest_from_exe),
    .data_sram_rdata     (data_sram_rdata),
    .ready_go            (ready_go),
    .WB_allow_in         (WB_allow_in),
    .inst_mem            (inst_mem),
    .pc_mem              (pc_mem),
    .final_result        (final_result),
    .reg_en              (reg_en),
    .dest                (dest),
    .valid               (valid),
    .forward_data_mem    (forward_data_mem),
    .forward_en_mem      (forward_en_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [31:0] inst,
                                      input logic [31:0] word,
                                      input logic [31:0] addr);
    int unsigned op, b, h;
    op = inst >> 22;
    b = (word >> (8 * (addr % 4))) % 256;
    h = ((addr / 2) % 2 == 1) ? (word >> 16) : (word % 65536);
    case (op)
      'h0a0: return (b >= 128) ? b - 256 : b;
      'h0a1: return (h >= 32768) ? h - 65536 : h;
      'h0a8: return b;
      'h0a9: return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [9:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:22] = op;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [31:0] word, fr;
    logic wb_go;
    word = m_first ? data_sram_rdata : m_word;
    fr = m_ld ? ext(m_inst, word, m_alu) : m_alu;
    wb_go = !m_valid || WB_allow_in;
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("ready_go", {31'd0, ready_go}, {31'd0, m_valid});
    chk("allow_in", {31'd0, allow_in}, {31'd0, wb_go});
    chk("pc_mem", pc_mem, m_pc);
    chk("inst_mem", inst_mem, m_inst);
    chk("final_result", final_result, fr);
    chk("fwd_data", forward_data_mem, fr);
    chk("reg_en", {31'd0, reg_en}, {31'd0, m_re});
    chk("dest", {27'd0, dest}, {27'd0, m_dst});
    chk("fwd_en", {31'd0, forward_en_mem}, {31'd0, m_valid & m_re});
  endtask

  task automatic model_reset();
    m_valid = 0; m_first = 0; m_re = 0; m_ld = 0;
    m_inst = 0; m_pc = 0; m_alu = 0; m_word = 0; m_dst = 0;
  endtask

  task automatic drive(input logic rge, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic re, input logic ld,
                       input logic [4:0] dst, input logic [31:0] rd,
                       input logic wb);
    ready_go_exe = rge; inst_from_exe = inst; pc_from_exe = pc;
    alu_result_from_exe = alu; reg_en_from_exe = re;
    mem_ld_from_exe = ld; dest_from_exe = dst;
    data_sram_rdata = rd; WB_allow_in = wb;
  endtask

  // check, advance one clock edge, update the model, return at negedge
  task automatic cyc();
    logic acc;
    #1 chk_model();
    @(posedge clk);
    acc = ready_go_exe && (!m_valid || WB_allow_in);
    if (m_first) m_word = data_sram_rdata;
    if (acc) begin
      m_valid = 1; m_first = 1;
      m_inst = inst_from_exe; m_pc = pc_from_exe;
      m_alu = alu_result_from_exe; m_re = reg_en_from_exe;
      m_ld = mem_ld_from_exe; m_dst = dest_from_exe;
    end else begin
      if (m_valid && WB_allow_in) m_valid = 0;
      m_first = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1 model_reset();
    chk_model();
    chk("rst_fr", final_result, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [9:0] ops [6];
  logic [31:0] a;

  initial begin
    ops[0] = 10'h0a0; ops[1] = 10'h0a1; ops[2] = 10'h0a2;
    ops[3] = 10'h0a8; ops[4] = 10'h0a9; ops[5] = 10'h011;
    model_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_allow", {31'd0, allow_in}, 32'd1);

    // back-to-back ALU ops
    drive(1, mk(10'h011), 32'h100, 32'h11, 1, 0, 5'd1, 0, 1); cyc();
    chk("b2b_0", final_result, 32'h11);
    drive(1, mk(10'h011), 32'h104, 32'h22, 1, 0, 5'd2, 0, 1); cyc();
    chk("b2b_1", final_result, 32'h22);
    drive(1, mk(10'h011), 32'h108, 32'h33, 1, 0, 5'd3, 0, 1); cyc();
    chk("b2b_2", final_result, 32'h33);
    chk("b2b_fwd", {31'd0, forward_en_mem}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();

    // ld.w across a three-cycle WB stall
    drive(1, mk(10'h0a2), 32'h200, 32'h1000, 1, 1, 5'd4, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0); cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, mk(10'h0a2), 32'h300, 32'h2000, 1, 1, 5'd5,
            32'h12345678, 0);
      #1 chk("stall_fr", final_result, 32'hDEADBEEF);
      chk("stall_allow", {31'd0, allow_in}, 32'd0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1);
    #1 chk("rel_fr", final_result, 32'hDEADBEEF);
    cyc();
    chk("rel_gone", {31'd0, valid}, 32'd0);

    // byte/half extension
    for (int i = 0; i < 5; i++) begin
      logic [9:0] op;
      logic [31:0] ad, ex;
      case (i)
        0: begin op = 10'h0a0; ad = 0; ex = 32'h00000001; end
        1: begin op = 10'h0a0; ad = 2; ex = 32'hFFFFFFFF; end
        2: begin op = 10'h0a8; ad = 3; ex = 32'h00000080; end
        3: begin op = 10'h0a1; ad = 2; ex = 32'hFFFF80FF; end
        default: begin op = 10'h0a9; ad = 0; ex = 32'h00007F01; end
      endcase
      drive(1, mk(op), 32'h400 + ad, 32'h3000 + ad, 1, 1, 5'd6, 0, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h80FF7F01, 1);
      #1 chk("ext", final_result, ex);
      cyc();
    end

    // simultaneous accept and departure, each load gets its own rdata
    drive(1, mk(10'h0a2), 32'h500, 32'h4000, 1, 1, 5'd7, 0, 1); cyc();
    drive(1, mk(10'h0a2), 32'h504, 32'h4004, 1, 1, 5'd8, 32'hAAAA0001, 1);
    #1 chk("sim_fr0", final_result, 32'hAAAA0001);
    cyc();
    chk("sim_pc", pc_mem, 32'h504);
    drive(0, 0, 0, 0, 0, 0, 0, 32'hBBBB0002, 1);
    #1 chk("sim_fr1", final_result, 32'hBBBB0002);
    cyc();

    // store passes through with reg_en=0
    drive(1, mk(10'h0a6), 32'h600, 32'h5008, 0, 0, 5'd0, 32'hFFFF, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("st_fwd", {31'd0, forward_en_mem}, 32'd0);
    chk("st_fr", final_result, 32'h5008);
    cyc();

    // reset during the first cycle of a stalled load
    drive(1, mk(10'h0a2), 32'h700, 32'h6000, 1, 1, 5'd9, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0);
    do_reset();
    chk("rst_allow2", {31'd0, allow_in}, 32'd1);
    cyc();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      drive(1'($urandom_range(0, 3) != 0), mk(ops[$urandom_range(0, 5)]),
            $urandom, a, 1'($urandom), 1'($urandom),
            5'($urandom), $urandom, 1'($urandom_range(0, 2) != 0));
      cyc();
      if (i == 200) begin
        do_reset();
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
